// File: rtl/elevator_dispatcher.sv
// Collective-control scheduler for one elevator car: latches calls, picks direction, drives motor and door.
// Optional macro DOOR_HOLD_EN: door_hold keeps reloading the door timer while the door is open.
module elevator_dispatcher #(
   parameter  int FLOORS      = 3,
   parameter  int DOOR_CYCLES = 16,
   localparam int FW          = $clog2(FLOORS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLOORS-1:0] car_call,
   input  logic [FLOORS-1:0] hall_up,
   input  logic [FLOORS-1:0] hall_dn,
   input  logic [FLOORS-1:0] floor_sns,
   input  logic              door_hold,
   output logic [1:0]        motor,
   output logic              door_open,
   output logic [FW-1:0]     cur_floor,
   output logic [FLOORS-1:0] pending
);

   localparam int                TW     = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TW-1:0]     T_LOAD = TW'(DOOR_CYCLES - 1);
   localparam logic [FLOORS-1:0] ONE    = FLOORS'(1);
   localparam logic [FLOORS-1:0] TOP    = ONE << (FLOORS - 1);

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   state_t            state_q, state_d;
   logic              dir_q, dir_d;
   logic [FW-1:0]     floor_q, floor_d;
   logic [FLOORS-1:0] car_q, car_d, up_q, up_d, dn_q, dn_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [1:0]        motor_q, motor_d;
   logic              door_q, door_d;

   logic [FLOORS-1:0] up_btn, dn_btn, cur_oh, nxt_oh, lat_mask, pend;
   logic [FW-1:0]     nxt_floor;
   logic              pend_ahead, pend_behind, nxt_ahead, sns_hit, stop_nxt, hit_cur, hold;

   // Floors strictly beyond the one-hot position oh, upward when up=1, else downward.
   function automatic logic [FLOORS-1:0] beyond(input logic [FLOORS-1:0] oh, input logic up);
      return up ? ~(oh | (oh - ONE)) : (oh - ONE);
   endfunction

   assign up_btn    = hall_up & ~TOP;
   assign dn_btn    = hall_dn & ~ONE;
   assign pend      = car_q | up_q | dn_q;
   assign cur_oh    = ONE << floor_q;
   assign nxt_oh    = dir_q ? (cur_oh << 1) : (cur_oh >> 1);
   assign nxt_floor = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);

   assign pend_ahead  = |(pend & beyond(cur_oh, dir_q));
   assign pend_behind = |(pend & beyond(cur_oh, ~dir_q));
   assign nxt_ahead   = |(pend & beyond(nxt_oh, dir_q));
   assign sns_hit     = |(floor_sns & nxt_oh);
   assign stop_nxt    = |(car_q & nxt_oh) | |((dir_q ? up_q : dn_q) & nxt_oh)
                        | |(nxt_oh & (TOP | ONE)) | ~nxt_ahead;

   // With the door open, calls for this floor refresh the dwell instead of latching.
   assign hit_cur  = |((car_call | up_btn | dn_btn) & cur_oh);
   assign lat_mask = (state_q == DOOR) ? ~cur_oh : '1;

`ifdef DOOR_HOLD_EN
   assign hold = door_hold;
`else
   logic unused_door_hold;
   assign unused_door_hold = door_hold;
   assign hold = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dir_q   <= 1'b1;
         floor_q <= '0;
         car_q   <= '0;
         up_q    <= '0;
         dn_q    <= '0;
         timer_q <= '0;
         motor_q <= 2'b00;
         door_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         floor_q <= floor_d;
         car_q   <= car_d;
         up_q    <= up_d;
         dn_q    <= dn_d;
         timer_q <= timer_d;
         motor_q <= motor_d;
         door_q  <= door_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      floor_d = floor_q;
      timer_d = timer_q;
      car_d   = car_q | (car_call & lat_mask);
      up_d    = up_q | (up_btn & lat_mask);
      dn_d    = dn_q | (dn_btn & lat_mask);
      unique case (state_q)
         IDLE: begin
            if (|(pend & cur_oh)) begin
               state_d = DOOR;
               timer_d = T_LOAD;
               car_d   = car_d & ~cur_oh;
               up_d    = up_d & ~cur_oh;
               dn_d    = dn_d & ~cur_oh;
            end else if (pend_ahead) begin
               state_d = MOVE;
            end else if (pend_behind) begin
               dir_d   = ~dir_q;
               state_d = MOVE;
            end
         end
         MOVE: begin
            if (sns_hit) begin
               floor_d = nxt_floor;
               if (stop_nxt) begin
                  state_d = DOOR;
                  timer_d = T_LOAD;
                  car_d   = car_d & ~nxt_oh;
                  if (dir_q) up_d = up_d & ~nxt_oh;
                  else       dn_d = dn_d & ~nxt_oh;
                  if (!nxt_ahead) begin
                     if (dir_q) dn_d = dn_d & ~nxt_oh;
                     else       up_d = up_d & ~nxt_oh;
                  end
               end
            end
         end
         DOOR: begin
            if (hit_cur || hold) begin
               timer_d = T_LOAD;
            end else if (timer_q != '0) begin
               timer_d = timer_q - TW'(1);
            end else if (pend_ahead) begin
               state_d = MOVE;
            end else if (pend_behind) begin
               dir_d   = ~dir_q;
               state_d = MOVE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      motor_d = 2'b00;
      door_d  = 1'b0;
      if (state_d == MOVE) motor_d = dir_d ? 2'b10 : 2'b01;
      if (state_d == DOOR) door_d = 1'b1;
   end

   assign motor     = motor_q;
   assign door_open = door_q;
   assign cur_floor = floor_q;
   assign pending   = pend;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed bench for elevator_dispatcher (FLOORS=3, DOOR_CYCLES=4) with a floor-level behavioural model.
module tb_elevator_dispatcher;
   localparam int F  = 3;
   localparam int DC = 4;
   localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [F-1:0] car_call, hall_up, hall_dn, floor_sns, pending;
   logic         door_hold, door_open;
   logic [1:0]   motor;
   logic [1:0]   cur_floor;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   bit m_car[F], m_up[F], m_dn[F];
   int m_floor, m_dir, m_mode, m_left;

   elevator_dispatcher #(.FLOORS(F), .DOOR_CYCLES(DC)) dut (
      .clk(clk), .rst_n(rst_n), .car_call(car_call), .hall_up(hall_up), .hall_dn(hall_dn),
      .floor_sns(floor_sns), .door_hold(door_hold), .motor(motor), .door_open(door_open),
      .cur_floor(cur_floor), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_pend(int i);
      return m_car[i] | m_up[i] | m_dn[i];
   endfunction

   function automatic bit m_beyond(int f, int d);
      for (int j = 0; j < F; j++) if ((j - f) * d > 0 && m_pend(j)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_pending();
      logic [31:0] p = 0;
      for (int i = 0; i < F; i++) p[i] = m_pend(i);
      return p;
   endfunction

   function automatic logic [31:0] m_motor();
      if (m_mode != M_MOVE) return 0;
      return (m_dir > 0) ? 2 : 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < F; i++) begin
         m_car[i] = 0; m_up[i] = 0; m_dn[i] = 0;
      end
      m_floor = 0; m_dir = 1; m_mode = M_IDLE; m_left = 0;
   endtask

   // One clock edge of the car, decided on the requests as they stood before the edge.
   task automatic model_step();
      bit nc[F], nu[F], nd[F];
      bit call_here, hold_now, stop, more;
      int nf;
      call_here = 0;
      hold_now  = 0;
`ifdef DOOR_HOLD_EN
      hold_now = door_hold;
`endif
      for (int i = 0; i < F; i++) begin
         bit bc, bu, bd;
         bc = car_call[i];
         bu = hall_up[i] && (i < F - 1);
         bd = hall_dn[i] && (i > 0);
         if (m_mode == M_DOOR && i == m_floor) begin
            call_here = call_here | bc | bu | bd;
            nc[i] = m_car[i]; nu[i] = m_up[i]; nd[i] = m_dn[i];
         end else begin
            nc[i] = m_car[i] | bc; nu[i] = m_up[i] | bu; nd[i] = m_dn[i] | bd;
         end
      end
      case (m_mode)
         M_IDLE: begin
            if (m_pend(m_floor)) begin
               m_mode = M_DOOR; m_left = DC;
               nc[m_floor] = 0; nu[m_floor] = 0; nd[m_floor] = 0;
            end else if (m_beyond(m_floor, m_dir)) begin
               m_mode = M_MOVE;
            end else if (m_beyond(m_floor, -m_dir)) begin
               m_dir = -m_dir; m_mode = M_MOVE;
            end
         end
         M_MOVE: begin
            nf = m_floor + m_dir;
            if (nf >= 0 && nf < F && floor_sns[nf]) begin
               more = m_beyond(nf, m_dir);
               stop = m_car[nf] || (m_dir > 0 ? m_up[nf] : m_dn[nf]) || nf == 0 || nf == F - 1 || !more;
               m_floor = nf;
               if (stop) begin
                  m_mode = M_DOOR; m_left = DC;
                  nc[nf] = 0;
                  if (m_dir > 0 || !more) nu[nf] = 0;
                  if (m_dir < 0 || !more) nd[nf] = 0;
               end
            end
         end
         default: begin
            if (call_here || hold_now) m_left = DC;
            else if (m_left > 1) m_left = m_left - 1;
            else if (m_beyond(m_floor, m_dir)) m_mode = M_MOVE;
            else if (m_beyond(m_floor, -m_dir)) begin
               m_dir = -m_dir; m_mode = M_MOVE;
            end else m_mode = M_IDLE;
         end
      endcase
      for (int i = 0; i < F; i++) begin
         m_car[i] = nc[i]; m_up[i] = nu[i]; m_dn[i] = nd[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      else model_reset();
      #1;
   endtask

   task automatic count_door(input int start, output int n);
      n = start;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (door_open) n++;
         else break;
      end
   endtask

   task automatic do_reset();
      chk_en = 0;
      car_call = '0; hall_up = '0; hall_dn = '0; floor_sns = '0; door_hold = 1'b0;
      rst_n = 1'b0;
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
      chk_en = 1;
   endtask

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk("model_motor", motor, m_motor());
         chk("model_door", door_open, (m_mode == M_DOOR) ? 1 : 0);
         chk("model_floor", cur_floor, m_floor);
         chk("model_pending", pending, m_pending());
         chk("never_both", (motor != 2'b00 && door_open) ? 1 : 0, 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0;
      do_reset();
      chk("rst_motor", motor, 2'b00);
      chk("rst_door", door_open, 1'b0);
      chk("rst_floor", cur_floor, 2'd0);
      chk("rst_pending", pending, 3'b000);

      // Reset while moving up.
      car_call = 3'b100; tick(); car_call = '0;
      tick();
      chk("r_motor_up", motor, 2'b10);
      floor_sns = 3'b010; tick();
      chk("r_floor1", cur_floor, 2'd1);
      #2 rst_n = 1'b0; chk_en = 0;
      #1;
      chk("r_async_motor", motor, 2'b00);
      chk("r_async_floor", cur_floor, 2'd0);
      chk("r_async_pending", pending, 3'b000);
      model_reset();
      tick();
      floor_sns = '0; rst_n = 1'b1; chk_en = 1;

      // Single car call to the top floor.
      car_call = 3'b100; tick(); car_call = '0;
      chk("s1_pending", pending, 3'b100);
      tick();
      chk("s1_motor", motor, 2'b10);
      floor_sns = 3'b010; tick();
      chk("s1_pass_floor", cur_floor, 2'd1);
      chk("s1_pass_motor", motor, 2'b10);
      floor_sns = 3'b100; tick(); floor_sns = '0;
      chk("s1_stop_floor", cur_floor, 2'd2);
      chk("s1_stop_motor", motor, 2'b00);
      chk("s1_stop_door", door_open, 1'b1);
      count_door(1, n);
      chk("s1_dwell", n, DC);
      chk("s1_idle_pending", pending, 3'b000);
      chk("s1_idle_motor", motor, 2'b00);

      // Ignored top-floor up button; call at the current floor while idle.
      hall_up = 3'b100; tick(); hall_up = '0;
      chk("b_top_up_ignored", pending, 3'b000);
      hall_dn = 3'b100; tick();
      chk("b_here_latched", pending, 3'b100);
      tick(); hall_dn = '0;
      chk("b_here_door", door_open, 1'b1);
      chk("b_clear_wins", pending, 3'b000);
      count_door(1, n);
      chk("b_dwell", n, DC);

      // Down call at floor 1 is passed going up, served coming back down.
      do_reset();
      car_call = 3'b100; tick(); car_call = '0;
      tick();
      hall_dn = 3'b010; tick(); hall_dn = '0;
      chk("s2_pending", pending, 3'b110);
      floor_sns = 3'b010; tick();
      chk("s2_pass_floor", cur_floor, 2'd1);
      chk("s2_pass_motor", motor, 2'b10);
      floor_sns = 3'b100; tick(); floor_sns = '0;
      chk("s2_top_door", door_open, 1'b1);
      chk("s2_top_pending", pending, 3'b010);
      count_door(1, n);
      chk("s2_top_dwell", n, DC);
      chk("s2_motor_down", motor, 2'b01);
      floor_sns = 3'b010; tick(); floor_sns = '0;
      chk("s2_stop_floor", cur_floor, 2'd1);
      chk("s2_stop_door", door_open, 1'b1);
      chk("s2_stop_pending", pending, 3'b000);
      count_door(1, n);
      chk("s2_idle_motor", motor, 2'b00);

      // Up call at floor 1 on the way up, with a door reload by a same-floor call.
      do_reset();
      hall_up = 3'b010; car_call = 3'b100; tick(); hall_up = '0; car_call = '0;
      chk("s3_pending", pending, 3'b110);
      tick();
      chk("s3_motor", motor, 2'b10);
      floor_sns = 3'b010; tick(); floor_sns = '0;
      chk("s3_stop_floor", cur_floor, 2'd1);
      chk("s3_stop_door", door_open, 1'b1);
      chk("s3_only_up_cleared", pending, 3'b100);
      tick(); tick();
      car_call = 3'b010; tick(); car_call = '0;
      chk("s4_not_latched", pending, 3'b100);
      chk("s4_door_open", door_open, 1'b1);
      count_door(1, n);
      chk("s4_reload_dwell", n, DC);
      chk("s3_resume_motor", motor, 2'b10);
      floor_sns = 3'b100; tick(); floor_sns = '0;
      chk("s3_top_floor", cur_floor, 2'd2);
      chk("s3_top_door", door_open, 1'b1);

      // Door hold for ten cycles.
      n = 1;
      for (int i = 0; i < 40; i++) begin
         door_hold = (i < 10);
         tick();
         if (door_open) n++;
         else break;
      end
      door_hold = 1'b0;
`ifdef DOOR_HOLD_EN
      chk("hold_dwell", n, 10 + DC);
`else
      chk("hold_dwell", n, DC);
`endif
      chk("end_pending", pending, 3'b000);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
